// File: rtl/vco_cal_ctrl.sv
// VCO trim calibration: successive-approximation search on the trim code,
// one frequency window per bit, measured against a sampled edge target.
module vco_cal_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TRIM_W        = 5
) (
  input  logic              i_clk,
  input  logic              i_resetbAll,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [15:0]       i_target,
  input  logic [7:0]        i_tol,
  input  logic              i_vco_clk,
  output logic              o_resetbvco,
  output logic [TRIM_W-1:0] o_trim,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_locked,
  output logic [15:0]       o_count
);

  localparam int unsigned IW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [TRIM_W-1:0] TRIM_MSB = TRIM_W'(1) << (TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VRST,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [TRIM_W-1:0] save_q, save_d;
  logic [15:0]       tgt_q, tgt_d;
  logic [7:0]        tol_q, tol_d;
  logic [15:0]       edges_q, edges_d;
  logic [15:0]       count_q, count_d;
  logic              locked_q, locked_d;
  logic              rvco_q, rvco_d;
  logic [2:0]        sync_q;
  logic              vco_edge;
  logic [16:0]       diff;

  assign vco_edge = sync_q[1] & ~sync_q[2];

  always_comb begin
    if (edges_q >= tgt_q) diff = {1'b0, edges_q} - {1'b0, tgt_q};
    else                  diff = {1'b0, tgt_q} - {1'b0, edges_q};
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    trim_d   = trim_q;
    save_d   = save_q;
    tgt_d    = tgt_q;
    tol_d    = tol_q;
    edges_d  = edges_q;
    count_d  = count_q;
    locked_d = locked_q;
    if (state_q != S_IDLE && i_abort) begin
      state_d  = S_IDLE;
      trim_d   = save_q;
      locked_d = 1'b0;
      tmr_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_d  = S_VRST;
            bit_d    = IW'(TRIM_W - 1);
            save_d   = trim_q;
            trim_d   = TRIM_MSB;
            tgt_d    = i_target;
            tol_d    = i_tol;
            locked_d = 1'b0;
            tmr_d    = '0;
          end
        end
        S_VRST: begin
          if (tmr_q == 16'd1) begin
            state_d = S_SETTLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        S_SETTLE: begin
          edges_d = '0;
          if (tmr_q == SET_LAST) begin
            state_d = S_MEASURE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        S_MEASURE: begin
          if (vco_edge && edges_q != 16'hFFFF) edges_d = edges_q + 16'd1;
          if (tmr_q == WIN_LAST) begin
            state_d = S_COMPARE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        S_COMPARE: begin
          count_d = edges_q;
          if (edges_q > tgt_q) trim_d[bit_q] = 1'b0;
          if (bit_q != '0) begin
            trim_d[bit_q - IW'(1)] = 1'b1;
            bit_d   = bit_q - IW'(1);
            state_d = S_VRST;
          end else begin
            // Lock is judged on the final trial's count, shown with o_done.
            state_d  = S_DONE;
            locked_d = (diff <= {9'b0, tol_q});
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    rvco_d = (state_d != S_VRST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetbAll) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      trim_q   <= '0;
      save_q   <= '0;
      tgt_q    <= '0;
      tol_q    <= '0;
      edges_q  <= '0;
      count_q  <= '0;
      locked_q <= 1'b0;
      rvco_q   <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      trim_q   <= trim_d;
      save_q   <= save_d;
      tgt_q    <= tgt_d;
      tol_q    <= tol_d;
      edges_q  <= edges_d;
      count_q  <= count_d;
      locked_q <= locked_d;
      rvco_q   <= rvco_d;
      sync_q   <= {sync_q[1:0], i_vco_clk};
    end
  end

  assign o_resetbvco = rvco_q;
  assign o_trim      = trim_q;
  assign o_busy      = (state_q == S_VRST) || (state_q == S_SETTLE) ||
                       (state_q == S_MEASURE) || (state_q == S_COMPARE);
  assign o_done      = (state_q == S_DONE);
  assign o_locked    = locked_q;
  assign o_count     = count_q;

endmodule
